aes_key_schedule: RTL

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

---
 rtl/aes_key_schedule.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule.sv
// AES key schedule (FIPS-197 key expansion), one expanded word per clock.
//
// Loads a 128/192/256-bit cipher key and expands it into NR+1 round keys held in
// internal storage. Round keys are read combinationally by index.
//
// Parameters:
//   KEY_LEN     cipher key width: 128, 192 or 256
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   Secret_key  cipher key, bit KEY_LEN-1 is the MSB of word w0
//   valid_in    key-load request, accepted when ready_out is high
//   ready_out   high in IDLE and DONE
//   rd_idx      round index for the read port
//   rd_rev      (only with KEY_SCHED_REV_READ_EN) read round NR-rd_idx instead
//   rk_out      round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, zero if rd_idx > NR
//   valid_out   bit r set once round key r is complete
//   done        one-cycle pulse when the last word is written
//
// Optional feature macro: KEY_SCHED_REV_READ_EN adds the rd_rev input.
module aes_key_schedule #(
  parameter int unsigned KEY_LEN = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_LEN-1:0] Secret_key,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [3:0]         rd_idx,
`ifdef KEY_SCHED_REV_READ_EN
  input  logic               rd_rev,
`endif
  output logic [127:0]       rk_out,
  output logic [14:0]        valid_out,
  output logic               done
);

  localparam int unsigned NK = KEY_LEN / 32;
  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_key_schedule: KEY_LEN must be 128, 192 or 256");
  end

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  i_q, i_d;       // index of the word written this cycle
  logic [2:0]  j_q, j_d;       // i mod NK, kept as a counter to avoid a divider
  logic [7:0]  rcon_q, rcon_d;
  logic [14:0] valid_q, valid_d;
  logic        done_q, done_d;
  logic        load, wr_en;

  logic [31:0] w_q [NW];
  logic [31:0] w_prev, w_back, sub_in, sub_out, new_word;
  logic        rot_step, sub_only_step;

  // Datapath: one S-box word lookup shared by both substitution cases.
  always_comb begin
    w_prev        = w_q[i_q - 6'd1];
    w_back        = w_q[i_q - 6'(NK)];
    rot_step      = (j_q == 3'd0);
    sub_only_step = (NK == 8) && (j_q == 3'd4);
    sub_in        = rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out       = sub_word(sub_in);
    if (rot_step) begin
      new_word = w_back ^ sub_out ^ {rcon_q, 24'h000000};
    end else if (sub_only_step) begin
      new_word = w_back ^ sub_out;
    end else begin
      new_word = w_back ^ w_prev;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (valid_in) begin
          load    = 1'b1;
          state_d = StExpand;
          i_d     = 6'(NK);
          j_d     = 3'd0;
          rcon_d  = 8'h01;
          valid_d = '0;
        end
      end
      StExpand: begin
        wr_en = 1'b1;
        i_d   = i_q + 6'd1;
        j_d   = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
        if (rot_step) begin
          rcon_d = xtime(rcon_q);
        end
        // A round is complete once its last word (4r+3) is at or below the one written now.
        for (int r = 0; r < 15; r++) begin
          if (r <= int'(NR) && (4 * r + 3) <= int'(i_q)) begin
            valid_d[r] = 1'b1;
          end
        end
        if (i_q == 6'(NW - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      rcon_q  <= 8'h01;
      valid_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Key storage has no reset: contents are hidden behind valid_out.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < int'(NK); k++) begin
        w_q[k] <= Secret_key[KEY_LEN - 1 - 32 * k -: 32];
      end
    end else if (wr_en) begin
      w_q[i_q] <= new_word;
    end
  end

  logic [3:0] rd_sel;
  logic [5:0] rd_base;

  always_comb begin
    rd_sel = rd_idx;
`ifdef KEY_SCHED_REV_READ_EN
    if (rd_rev) begin
      rd_sel = 4'(NR) - rd_idx;
    end
`endif
    rd_base = {rd_sel, 2'b00};
    rk_out  = '0;
    if (rd_idx <= 4'(NR)) begin
      rk_out = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

  assign ready_out = (state_q != StExpand);
  assign valid_out = valid_q;
  assign done      = done_q;

endmodule
